// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects from the latched opcode.
module mips_control_fsm (
  input  logic        clk,
  input  logic        resetN,
  input  logic        run,
  input  logic [5:0]  opCode,
  output logic        pcWrite,
  output logic        branch,
  output logic        regDst,
  output logic        regWrite,
  output logic        aluSrc,
  output logic        memToReg,
  output logic        memRead,
  output logic        memWrite,
  output logic        loadFullWord,
  output logic        loadSigned,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegalOp,
  output logic [15:0] instrCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } stateT;

  stateT       curState, nextState;
  logic [5:0]  irOp;
  logic [15:0] retired;

  logic isR, isAddi, isLw, isLh, isLhu, isSw, isBeq, isHalt, isLoad, isMemOp, isExec;

  assign isR     = (irOp == OP_R);
  assign isAddi  = (irOp == OP_ADDI);
  assign isLw    = (irOp == OP_LW);
  assign isLh    = (irOp == OP_LH);
  assign isLhu   = (irOp == OP_LHU);
  assign isSw    = (irOp == OP_SW);
  assign isBeq   = (irOp == OP_BEQ);
  assign isHalt  = (irOp == OP_HALT);
  assign isLoad  = isLw | isLh | isLhu;
  assign isMemOp = isLoad | isSw;
  assign isExec  = isR | isAddi | isMemOp | isBeq;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      curState <= IDLE;
      irOp     <= 6'd0;
    end else begin
      curState <= nextState;
      if (curState == FETCH) irOp <= opCode;
    end
  end

  // An instruction's last cycle falls back to FETCH, or IDLE once run has dropped.
  always_comb begin
    nextState = IDLE;
    case (curState)
      IDLE:    nextState = run ? FETCH : IDLE;
      FETCH:   nextState = DECODE;
      DECODE:  nextState = isHalt ? HALT : (isExec ? EXEC : FETCH);
      EXEC: begin
        if (isR || isAddi)  nextState = WB;
        else if (isMemOp)   nextState = MEM;
        else                nextState = run ? FETCH : IDLE;
      end
      MEM:     nextState = isLoad ? WB : (run ? FETCH : IDLE);
      WB:      nextState = run ? FETCH : IDLE;
      HALT:    nextState = HALT;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    pcWrite      = 1'b0;
    branch       = 1'b0;
    regDst       = 1'b0;
    regWrite     = 1'b0;
    aluSrc       = 1'b0;
    memToReg     = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    loadFullWord = 1'b0;
    loadSigned   = 1'b0;
    halted       = 1'b0;
    illegalOp    = 1'b0;
    case (curState)
      DECODE: illegalOp = !isHalt && !isExec;
      EXEC: begin
        aluSrc  = isAddi | isMemOp;
        regDst  = isR;
        branch  = isBeq;
        pcWrite = isBeq;
      end
      MEM: begin
        memRead      = isLoad;
        memWrite     = isSw;
        pcWrite      = isSw;
        loadFullWord = isLw;
        loadSigned   = isLh;
      end
      WB: begin
        regWrite     = 1'b1;
        pcWrite      = 1'b1;
        regDst       = isR;
        memToReg     = isLoad;
        // Load controls stay up so the read data is stable through the write.
        memRead      = isLoad;
        loadFullWord = isLw;
        loadSigned   = isLh;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)      retired <= 16'd0;
    else if (pcWrite) retired <= retired + 16'd1;
  end

  assign instrCount = retired;
  assign state      = curState;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: per-instruction vector table fed through an
// expected-cycle queue, plus hand sequences for reset, halt, run-drop and wrap.
module tb_mips_control_fsm;

  logic        clk = 1'b0;
  logic        resetN;
  logic        run;
  logic [5:0]  opCode;
  logic        pcWrite, branch, regDst, regWrite, aluSrc, memToReg;
  logic        memRead, memWrite, loadFullWord, loadSigned, halted, illegalOp;
  logic [2:0]  state;
  logic [15:0] instrCount;

  mips_control_fsm dut (
    .clk(clk), .resetN(resetN), .run(run), .opCode(opCode),
    .pcWrite(pcWrite), .branch(branch), .regDst(regDst), .regWrite(regWrite),
    .aluSrc(aluSrc), .memToReg(memToReg), .memRead(memRead), .memWrite(memWrite),
    .loadFullWord(loadFullWord), .loadSigned(loadSigned), .state(state),
    .halted(halted), .illegalOp(illegalOp), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] Z   = 12'h000, PCW = 12'h800, BR  = 12'h400, RD  = 12'h200;
  localparam logic [11:0] RW  = 12'h100, AS  = 12'h080, MTR = 12'h040, MR  = 12'h020;
  localparam logic [11:0] MW  = 12'h010, LFW = 12'h008, LS  = 12'h004, HLT = 12'h002;
  localparam logic [11:0] ILL = 12'h001;
  localparam logic [2:0]  SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5, SH = 3'd6;

  logic [11:0] obs;
  assign obs = {pcWrite, branch, regDst, regWrite, aluSrc, memToReg,
                memRead, memWrite, loadFullWord, loadSigned, halted, illegalOp};

  typedef struct {
    logic [5:0]  op;
    int          lat;
    int          dCnt;
    logic [2:0]  st[5];
    logic [11:0] ou[5];
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [11:0] ou;
  } exp_t;

  vec_t        vt[9];
  exp_t        sbq[$];
  logic [15:0] expCount;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] s, input logic [11:0] o);
    exp_t e;
    e.st = s;
    e.ou = o;
    sbq.push_back(e);
  endtask

  task automatic popCheck(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      check({nm, "_sbEmpty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      check({nm, "_state"}, int'(state), int'(e.st));
      check({nm, "_outs"}, int'(obs), int'(e.ou));
    end
  endtask

  task automatic waitFetch();
    int n = 0;
    while (state !== SF && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) check("fetchTimeout", int'(state), int'(SF));
  endtask

  // Present v.op in FETCH, queue every expected cycle, then compare cycle by cycle.
  task automatic runVec(input vec_t v, input int dropAt, input string nm);
    waitFetch();
    opCode = v.op;
    for (int k = 0; k < v.lat; k++) push(v.st[k], v.ou[k]);
    for (int k = 0; k < v.lat; k++) begin
      if (k > 0) @(negedge clk);
      if (k == dropAt) run = 1'b0;
      popCheck(nm);
    end
    @(negedge clk);
    expCount = expCount + 16'(v.dCnt);
    check({nm, "_count"}, int'(instrCount), int'(expCount));
  endtask

  initial begin
    vt[0].op = 6'h00; vt[0].lat = 4; vt[0].dCnt = 1; vt[0].st = '{SF, SD, SE, SW, SI};
    vt[0].ou = '{Z, Z, RD, RW | RD | PCW, Z};
    vt[1].op = 6'h08; vt[1].lat = 4; vt[1].dCnt = 1; vt[1].st = '{SF, SD, SE, SW, SI};
    vt[1].ou = '{Z, Z, AS, RW | PCW, Z};
    vt[2].op = 6'h23; vt[2].lat = 5; vt[2].dCnt = 1; vt[2].st = '{SF, SD, SE, SM, SW};
    vt[2].ou = '{Z, Z, AS, MR | LFW, RW | PCW | MTR | MR | LFW};
    vt[3].op = 6'h21; vt[3].lat = 5; vt[3].dCnt = 1; vt[3].st = '{SF, SD, SE, SM, SW};
    vt[3].ou = '{Z, Z, AS, MR | LS, RW | PCW | MTR | MR | LS};
    vt[4].op = 6'h25; vt[4].lat = 5; vt[4].dCnt = 1; vt[4].st = '{SF, SD, SE, SM, SW};
    vt[4].ou = '{Z, Z, AS, MR, RW | PCW | MTR | MR};
    vt[5].op = 6'h2B; vt[5].lat = 4; vt[5].dCnt = 1; vt[5].st = '{SF, SD, SE, SM, SI};
    vt[5].ou = '{Z, Z, AS, MW | PCW, Z};
    vt[6].op = 6'h04; vt[6].lat = 3; vt[6].dCnt = 1; vt[6].st = '{SF, SD, SE, SI, SI};
    vt[6].ou = '{Z, Z, BR | PCW, Z, Z};
    vt[7].op = 6'h15; vt[7].lat = 2; vt[7].dCnt = 0; vt[7].st = '{SF, SD, SI, SI, SI};
    vt[7].ou = '{Z, ILL, Z, Z, Z};
    vt[8].op = 6'h02; vt[8].lat = 2; vt[8].dCnt = 0; vt[8].st = '{SF, SD, SI, SI, SI};
    vt[8].ou = '{Z, ILL, Z, Z, Z};

    resetN = 1'b0; run = 1'b0; opCode = 6'h00; expCount = 16'd0;
    #3;
    check("rst_state", int'(state), 0);
    check("rst_outs", int'(obs), 0);
    check("rst_count", int'(instrCount), 0);
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("idle_noRun", int'(state), int'(SI));
    run = 1'b1;
    @(negedge clk);
    check("firstFetch", int'(state), int'(SF));

    for (int i = 0; i < 9; i++) runVec(vt[i], -1, $sformatf("vec%0d", i));

    // run drops while lw is in DECODE: it still retires, then the FSM parks in IDLE.
    runVec(vt[2], 1, "lwDrop");
    for (int i = 0; i < 4; i++) begin
      check("lwDrop_idle", int'(state), int'(SI));
      @(negedge clk);
    end

    force dut.retired = 16'hFFFF;
    @(negedge clk);
    release dut.retired;
    expCount = 16'hFFFF;
    @(negedge clk);
    check("preload", int'(instrCount), int'(expCount));
    run = 1'b1;
    runVec(vt[6], -1, "wrapBeq");

    // Reset lands mid-EXEC of sw: outputs clear at once and no store follows.
    waitFetch();
    opCode = 6'h2B;
    push(SF, Z); push(SD, Z); push(SE, AS);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      popCheck("swRst");
    end
    #2 resetN = 1'b0;
    #1;
    check("swRst_asyncState", int'(state), int'(SI));
    check("swRst_asyncOuts", int'(obs), 0);
    check("swRst_asyncCount", int'(instrCount), 0);
    expCount = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("swRst_held", int'(obs), 0);
    end
    resetN = 1'b1;

    waitFetch();
    opCode = 6'h3F;
    push(SF, Z); push(SD, Z);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      popCheck("halt");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      push(SH, HLT);
      popCheck("haltHold");
      run = ~run;
    end
    check("halt_count", int'(instrCount), int'(expCount));
    resetN = 1'b0;
    #1;
    check("haltRst", int'(state), int'(SI));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 Parameters: none; the opcode map is fixed (R=000000, lw=100011, lh=100001, lhu=100101, sw=101011, beq=000100, addi=001000, halt=111111).
REQ-002 clk  input  1  single clock for the block; all state changes on posedge clk.
REQ-003 resetN  input  1  reset, asynchronous assert, active-low.
REQ-004 run  input  1  level; when high, the FSM may leave IDLE to fetch.
REQ-005 opCode  input  6  instruction[31:26] from instruction memory; valid during FETCH.
REQ-006 pcWrite  output  1  PC load strobe.
REQ-007 branch, regDst, regWrite, aluSrc, memToReg  output  1 each  datapath selects/enables.
REQ-008 memRead, memWrite, loadFullWord, loadSigned  output  1 each  data memory controls.
REQ-009 state  output  3  current state code.
REQ-010 halted  output  1  high while in HALT.
REQ-011 illegalOp  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 instrCount  output  16  count of retired instructions.

Function
REQ-013 States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 is unreachable and shall go to IDLE.
REQ-014 IDLE: the FSM goes to FETCH when run=1, else stays in IDLE.
REQ-015 FETCH: opCode is latched into internal register irOp on the FETCH->DECODE edge; next state is DECODE.
REQ-016 DECODE, by irOp: halt->HALT; supported opcode->EXEC; other->FETCH with illegalOp=1 during the DECODE cycle, no pcWrite, and instrCount unchanged.
REQ-017 EXEC: R/addi->WB; lw/lh/lhu/sw->MEM; beq->FETCH (or IDLE if run=0).
REQ-018 MEM: lw/lh/lhu->WB; sw->FETCH (or IDLE if run=0).
REQ-019 WB->FETCH (or IDLE if run=0).
REQ-020 HALT is held until resetN is asserted; run is ignored in HALT.
REQ-021 Latency in cycles, FETCH to completion: beq 3, R 4, addi 4, sw 4, lw/lh/lhu 5.
REQ-022 Outputs are Moore, decoded from state and irOp only, never from opCode directly; all outputs not listed in a state are 0.
REQ-023 EXEC outputs: aluSrc=1 for addi/lw/lh/lhu/sw; regDst=1 for R; beq asserts branch=1 and pcWrite=1, and the datapath selects the target using aluZero.
REQ-024 MEM outputs: memRead=1 for loads; memWrite=1 and pcWrite=1 for sw; loadFullWord=1 for lw; loadSigned=1 for lh; both 0 for lhu.
REQ-025 WB outputs: regWrite=1 and pcWrite=1; R gives regDst=1, memToReg=0; addi gives regDst=0, memToReg=0; loads give regDst=0, memToReg=1, and hold memRead/loadFullWord/loadSigned at their MEM values.
REQ-026 pcWrite is asserted in exactly one cycle per retired instruction: the last cycle of that instruction.
REQ-027 instrCount increments by 1 on each posedge where pcWrite=1, and wraps from 0xFFFF to 0x0000.
REQ-028 regWrite and memWrite are never asserted in the same cycle.
REQ-029 run falling mid-instruction does not abort the instruction; the FSM completes it and then enters IDLE.

Reset
REQ-030 When resetN=0: state=IDLE, irOp=0, instrCount=0, and all 1-bit outputs are 0, immediately and without waiting for clk.
REQ-031 Reset asserted mid-instruction abandons it; no pcWrite, regWrite or memWrite is asserted after reset is applied.
REQ-032 Reset release is sampled on posedge clk; the first FETCH occurs no earlier than the first posedge after release with run=1.

Verification
REQ-033 run=1, opCode=000000 -> states 1,2,3,5,1; regWrite=regDst=pcWrite=1 in WB only; instrCount=1 after 4 cycles.
REQ-034 opCode=100001 (lh) -> 5 cycles; MEM: memRead=1, loadSigned=1, loadFullWord=0; WB: memToReg=1, regWrite=1.
REQ-035 opCode=000100 (beq) -> states 1,2,3; EXEC: branch=1, pcWrite=1; no regWrite; instrCount +1.
REQ-036 opCode=010101 -> illegalOp pulses in DECODE, return to FETCH, instrCount unchanged; opCode=111111 -> halted=1 held for 20 cycles with run toggling.
REQ-037 Preload 0xFFFF retirements, then one more -> instrCount=0x0000; assert resetN=0 mid-EXEC of sw -> all outputs 0 asynchronously, no memWrite.
REQ-038 run dropped during DECODE of lw -> lw completes in 5 cycles, then state=0 and stays there.
